// File: rtl/vga_frame_scheduler.sv
// rtl/vga_frame_scheduler.sv - VGA raster timing generator with a per-frame update-window scheduler
//
// Purpose: advances horizontal/vertical raster counters on each pixel strobe,
// produces registered active-low syncs and the active-video flag, and grants
// the game-logic update port one window per frame that opens exactly at the
// start of vertical blanking and closes at frame wrap at the latest.
//
// Ports:
//   clock        in   system clock
//   reset_n      in   asynchronous active-low reset
//   pix_en       in   pixel-rate strobe; raster advances only when 1
//   upd_req      in   update window request (level)
//   upd_done     in   update finished (1-cycle pulse, honoured only in grant)
//   hcount       out  horizontal position, 0..H_TOTAL-1
//   vcount       out  vertical position, 0..V_TOTAL-1
//   hsync        out  active-low horizontal sync
//   vsync        out  active-low vertical sync
//   video_on     out  1 inside the visible window
//   frame_start  out  1-cycle pulse when the raster wraps to (0,0)
//   upd_grant    out  update window open
//   upd_pending  out  request accepted, waiting for blanking
//   upd_overrun  out  1-cycle pulse: window closed by frame wrap without upd_done
`timescale 1ns/1ps

module vga_frame_scheduler #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pix_en,
  input  logic       upd_req,
  input  logic       upd_done,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start,
  output logic       upd_grant,
  output logic       upd_pending,
  output logic       upd_overrun
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEGIN   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEGIN   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_GRANT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_start_d;
  logic       upd_grant_q, upd_grant_d;
  logic       upd_pending_q, upd_pending_d;
  logic       upd_overrun_q, upd_overrun_d;

  logic       h_wrap;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       vb_start;
  logic       frame_evt;

  // Raster: sync/video flags are decoded from the next counts so that the
  // registered flags line up with the registered counters on the same cycle.
  always_comb begin : raster_comb
    h_wrap    = (hcount_q == H_LAST);
    h_next    = h_wrap ? 10'd0 : hcount_q + 10'd1;
    v_next    = vcount_q;
    if (h_wrap) begin
      v_next = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
    end
    vb_start  = pix_en && h_wrap && (vcount_q == V_VIS_LAST);
    frame_evt = pix_en && h_wrap && (vcount_q == V_LAST);

    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    frame_start_d = frame_evt;

    if (pix_en) begin
      hcount_d   = h_next;
      vcount_d   = v_next;
      hsync_d    = !((h_next >= HS_BEGIN) && (h_next < HS_END));
      vsync_d    = !((v_next >= VS_BEGIN) && (v_next < VS_END));
      video_on_d = (h_next < H_VIS) && (v_next < V_VIS);
    end
  end

  // Scheduler: a request only waits in PEND until the next blanking start, so
  // a request landing on the blanking-start cycle itself waits a whole frame.
  // Returning through IDLE for one cycle guarantees at most one grant per frame.
  always_comb begin : sched_comb
    state_d       = state_q;
    upd_overrun_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (upd_req) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (vb_start) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (upd_done) begin
          state_d = ST_IDLE;
        end else if (frame_evt) begin
          state_d       = ST_IDLE;
          upd_overrun_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    upd_pending_d = (state_d == ST_PEND);
    upd_grant_d   = (state_d == ST_GRANT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      upd_grant_q   <= 1'b0;
      upd_pending_q <= 1'b0;
      upd_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      upd_grant_q   <= upd_grant_d;
      upd_pending_q <= upd_pending_d;
      upd_overrun_q <= upd_overrun_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;
  assign upd_grant   = upd_grant_q;
  assign upd_pending = upd_pending_q;
  assign upd_overrun = upd_overrun_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// tb/tb_vga_frame_scheduler.sv - scoreboard bench for vga_frame_scheduler with a reduced raster
`timescale 1ns/1ps

module tb_vga_frame_scheduler;

  // Reduced raster keeps full frames short: 16 x 11 = 176 pixel strobes.
  localparam int HV = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int VV = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME_PIX = HT * VT;

  logic       clock    = 1'b0;
  logic       reset_n  = 1'b1;
  logic       pix_en   = 1'b0;
  logic       upd_req  = 1'b0;
  logic       upd_done = 1'b0;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;
  logic       upd_grant;
  logic       upd_pending;
  logic       upd_overrun;

  vga_frame_scheduler #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pix_en     (pix_en),
    .upd_req    (upd_req),
    .upd_done   (upd_done),
    .hcount     (hcount),
    .vcount     (vcount),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .frame_start(frame_start),
    .upd_grant  (upd_grant),
    .upd_pending(upd_pending),
    .upd_overrun(upd_overrun)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       to;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       von;
    logic       fs;
    logic       gr;
    logic       pe;
    logic       ov;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  exp_t mon_e;
  exp_t mon_a;

  // Reference model: raster position is just the strobe count modulo the frame.
  int m_p;
  bit m_started;
  bit m_pend;
  bit m_grant;
  bit m_fs;
  bit m_ov;
  bit rq_lvl = 1'b0;
  bit found;

  task automatic model_reset();
    m_p = 0; m_started = 0; m_pend = 0; m_grant = 0; m_fs = 0; m_ov = 0;
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    int   h;
    int   v;
    h     = m_p % HT;
    v     = m_p / HT;
    e.to  = 1'b0;
    e.h   = 10'(h);
    e.v   = 10'(v);
    e.hs  = m_started ? !(h >= HV + HF && h < HV + HF + HS) : 1'b1;
    e.vs  = m_started ? !(v >= VV + VF && v < VV + VF + VS) : 1'b1;
    e.von = m_started && h < HV && v < VV;
    e.fs  = m_fs;
    e.gr  = m_grant;
    e.pe  = m_pend;
    e.ov  = m_ov;
    return e;
  endfunction

  task automatic model_edge();
    bit vb;
    bit fr;
    int h;
    int v;
    if (!reset_n) begin
      model_reset();
      return;
    end
    h  = m_p % HT;
    v  = m_p / HT;
    vb = 0;
    fr = 0;
    if (pix_en) begin
      vb        = (h == HT - 1) && (v == VV - 1);
      fr        = (h == HT - 1) && (v == VT - 1);
      m_p       = (m_p + 1) % FRAME_PIX;
      m_started = 1;
    end
    m_fs = fr;
    m_ov = 0;
    if (m_grant) begin
      if (upd_done) m_grant = 0;
      else if (fr) begin m_grant = 0; m_ov = 1; end
    end else if (m_pend) begin
      if (vb) begin m_pend = 0; m_grant = 1; end
    end else if (upd_req) begin
      m_pend = 1;
    end
  endtask

  task automatic step(input logic pe, input logic rq, input logic dn);
    pix_en   = pe;
    upd_req  = rq;
    upd_done = dn;
    @(posedge clock);
    model_edge();
    sb_q.push_back(model_exp());
    #2;
  endtask

  task automatic wait_expired();
    exp_t e;
    e    = '0;
    e.to = 1'b1;
    sb_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      tests++;
      if (mon_e.to) begin
        fails++;
        $display("FAIL wait_bound @%0t: got no target state, required it within the cycle budget", $time);
      end else begin
        mon_a = {1'b0, hcount, vcount, hsync, vsync, video_on, frame_start,
                 upd_grant, upd_pending, upd_overrun};
        if (mon_a !== mon_e) begin
          fails++;
          $display("FAIL outputs @%0t: got h=%0d v=%0d hs=%b vs=%b von=%b fs=%b gr=%b pe=%b ov=%b, required h=%0d v=%0d hs=%b vs=%b von=%b fs=%b gr=%b pe=%b ov=%b",
                   $time, mon_a.h, mon_a.v, mon_a.hs, mon_a.vs, mon_a.von, mon_a.fs, mon_a.gr, mon_a.pe, mon_a.ov,
                   mon_e.h, mon_e.v, mon_e.hs, mon_e.vs, mon_e.von, mon_e.fs, mon_e.gr, mon_e.pe, mon_e.ov);
        end
      end
    end
  end

  initial begin
    model_reset();
    #1 reset_n = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Quarter-rate pixel strobe, random request levels and done pulses.
    for (int i = 0; i < 1600; i++) begin
      if ($urandom_range(0, 7) == 0) rq_lvl = !rq_lvl;
      step(i % 4 == 0, rq_lvl, $urandom_range(0, 19) == 0);
    end

    // Irregular strobe with mostly-high requests.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
    end

    // Request held, never done: grant runs to frame wrap and overruns.
    for (int i = 0; i < 2 * FRAME_PIX; i++) step(1'b1, 1'b1, 1'b0);

    // Done coincident with frame wrap: done must win over overrun.
    found = 0;
    for (int i = 0; i < 4 * FRAME_PIX; i++) begin
      if (m_grant && m_p == FRAME_PIX - 1) begin found = 1; break; end
      step(1'b1, 1'b1, 1'b0);
    end
    if (found) step(1'b1, 1'b1, 1'b1);
    else wait_expired();

    // Stray done pulses while idle.
    repeat (3) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, i % 2 == 0);

    // Request raised exactly on the blanking-start cycle from idle.
    found = 0;
    for (int i = 0; i < 4 * FRAME_PIX; i++) begin
      if (!m_pend && !m_grant && m_p == VV * HT - 1) begin found = 1; break; end
      step(1'b1, 1'b0, 1'b0);
    end
    if (found) step(1'b1, 1'b1, 1'b0);
    else wait_expired();
    for (int i = 0; i < 2 * FRAME_PIX; i++) step(1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant window.
    found = 0;
    for (int i = 0; i < 4 * FRAME_PIX; i++) begin
      if (m_grant && (m_p % HT) == 5) begin found = 1; break; end
      step(1'b1, 1'b1, 1'b0);
    end
    if (found) begin
      reset_n = 1'b0;
      sb_q.delete();
      model_reset();
      sb_q.push_back(model_exp());
      repeat (2) step(1'b1, 1'b1, 1'b0);
      reset_n = 1'b1;
    end else begin
      wait_expired();
    end
    for (int i = 0; i < 400; i++) begin
      step(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
    end

    #20;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
